tess_factor_unit: RTL and testbench
===================================

Name: tess_factor_unit

Overview:
- Parametrised adaptive tessellation-factor generator for the hull/tessellation front end. Handshaked; accepts one patch of up to 4 window-space control points (signed Q12.4).
- Serially computes per-edge screen length and maps each length to an integer tess factor through one shared multi-cycle divider.
- Supports triangle and quad domains; alpha and target are set at run time per patch.
- Results are held on a valid/ready output port until the consumer takes them.

Parameters:
- COORD_W, 16, signed coordinate width (Q12.4).
- TF_W, 8, tess factor width.
- ALPHA_W, 4, width of cfg_alpha.
- TMIN, 1, lower clamp for every computed factor.
- TMAX, 64, upper clamp; must be < 2^TF_W.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  patch present.
- in_ready  out  1  unit can accept a patch.
- in_mode  in  1  0 = triangle, 1 = quad.
- cfg_alpha  in  ALPHA_W  length scale numerator.
- cfg_target  in  COORD_W  target length per segment, in coordinate LSBs.
- x0,y0,x1,y1,x2,y2,x3,y3  in  COORD_W each  control points, signed; x3/y3 ignored in tri mode.
- out_valid  out  1  factors valid.
- out_ready  in  1  consumer accepts.
- outer0..outer3  out  TF_W each  edge factors.
- inner0, inner1  out  TF_W each  interior factors.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, in_ready=1, out_valid=0, all factor outputs 0.
  - Any in-flight patch is discarded.
- Input handshake: in_valid && in_ready. Mode, alpha, target and all coordinates are latched on that edge; in_ready drops the next cycle.
- Width rules (LEN_W = COORD_W+2, SC_W = LEN_W+ALPHA_W+1):
  - Differences are computed at COORD_W+1 bits signed; no wrap.
  - len = max(|dx|,|dy|) + (min(|dx|,|dy|)>>1), LEN_W bits.
  - scaled = cfg_alpha*len + (cfg_target>>1), SC_W bits.
  - q = floor(scaled/cfg_target), then clamped to [TMIN,TMAX].
  - cfg_target==0: every computed factor is TMAX; the divider is still run, and its result is ignored.
- Edge list:
  - Quad: E0=v0-v1, E1=v1-v2, E2=v2-v3, E3=v3-v0 drive outer0..3. D0=v0-v2 drives inner0; D1=v1-v3 drives inner1. 6 divisions.
  - Tri: E0=v0-v1, E1=v1-v2, E2=v2-v0 drive outer0..2. 3 divisions.
  - Tri: inner0 = max(outer0,outer1,outer2); outer3 = 0; inner1 = 0.
- FSM:
  - IDLE: handshake -> LEN (edge index 0).
  - LEN (1 cycle): form len and scaled, start divider -> DIV.
  - DIV (SC_W cycles, restoring, 1 quotient bit/cycle): on done, write the clamped factor to an internal result register.
    - More edges -> LEN with index+1.
    - Otherwise -> OUT. In tri mode the inner max is formed on this transition.
  - OUT: outputs are copied from the result registers on entry; out_valid=1.
    - out_valid && out_ready -> IDLE.
    - out_valid stays 1 and outputs stay unchanged until the handshake.
- Latency:
  - Handshake at cycle 0; out_valid is first high at cycle N*(SC_W+1)+1.
  - Defaults (SC_W=23): quad 145, tri 73.
  - in_ready returns the cycle after the output handshake. Throughput is 1 patch per latency+1 cycles minimum.
- Output port:
  - Factor outputs keep the previous patch's values outside OUT; they are only meaningful while out_valid=1.
  - out_ready is ignored when out_valid=0.
  - Input changes while in_ready=0 have no effect.
- Reset mid-operation: immediate return to reset values. The first patch after release behaves as if it follows power-on.

Decomposition:
- Package tess_pkg:
  - mode encoding (TESS_TRI=0, TESS_QUAD=1).
  - FSM state enum (IDLE, LEN, DIV, OUT).
  - edge-index-to-vertex-pair table.
  - LEN_W/SC_W derivation functions.
- Sub-module tess_seq_div:
  - Parametrised unsigned restoring divider with ports start, dividend, divisor, busy, done, quotient.
  - done is a 1-cycle pulse exactly SC_W cycles after start.
  - Same async active-low reset.

Test Plan:
- Quad 8-px square, alpha=1, target=16: v=(0,0),(128,0),(128,128),(0,128) -> outer0..3=8, inner0=inner1=12; out_valid first high at cycle 145.
- Tri, alpha=1, target=16: v=(0,0),(320,0),(0,160) -> outer=20,25,10,0; inner0=25, inner1=0; out_valid at cycle 73.
- Clamps:
  - Quad square side 4096, target=16 -> all outer=64, inner=64.
  - All vertices equal -> all six factors =1.
  - cfg_target=0 -> all quad factors 64.
- Negative coords: quad v=(-128,-128),(0,-128),(0,0),(-128,0), alpha=1, target=16 -> same results as the first scenario.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Outputs and out_valid stay stable and in_ready=0.
  - in_valid toggled with new data during this time is ignored.
  - Release -> in_ready=1 the next cycle.
- Reset: assert rst_n=0 mid-DIV of the 3rd edge.
  - Outputs go to 0 and in_ready=1 asynchronously.
  - After release, a new tri patch produces correct factors at cycle 73.

Source files
------------

// File: rtl/tess_pkg.sv
// ---------------------------------------------------------------------------
// tess_pkg
// Shared types and helpers for the tessellation-factor unit:
//   - domain mode encoding (triangle / quad)
//   - FSM state enum
//   - edge-index to vertex-pair table
//   - derived width helpers for edge length and scaled length
// No ports (package).
// ---------------------------------------------------------------------------
package tess_pkg;

  typedef enum logic {
    TESS_TRI  = 1'b0,
    TESS_QUAD = 1'b1
  } tess_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } tess_state_e;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } vpair_t;

  // Edge length is max + min/2 of two (COORD_W+1)-bit magnitudes.
  function automatic int len_w(input int coord_w);
    return coord_w + 2;
  endfunction

  // alpha * len plus the rounding term target/2.
  function automatic int sc_w(input int coord_w, input int alpha_w);
    return len_w(coord_w) + alpha_w + 1;
  endfunction

  // Indices 0..3 are the outer edges, 4..5 the quad diagonals. Only
  // edge 2 differs between domains: tri closes the loop back to v0.
  function automatic vpair_t edge_pair(input tess_mode_e mode, input logic [2:0] idx);
    vpair_t p;
    p = '{a: 2'd0, b: 2'd1};
    case (idx)
      3'd0: p = '{a: 2'd0, b: 2'd1};
      3'd1: p = '{a: 2'd1, b: 2'd2};
      3'd2: begin
        if (mode == TESS_QUAD) p = '{a: 2'd2, b: 2'd3};
        else                   p = '{a: 2'd2, b: 2'd0};
      end
      3'd3: p = '{a: 2'd3, b: 2'd0};
      3'd4: p = '{a: 2'd0, b: 2'd2};
      3'd5: p = '{a: 2'd1, b: 2'd3};
      default: p = '{a: 2'd0, b: 2'd1};
    endcase
    return p;
  endfunction

  // Index of the final division for the domain.
  function automatic logic [2:0] last_idx(input tess_mode_e mode);
    return (mode == TESS_QUAD) ? 3'd5 : 3'd2;
  endfunction

endpackage

// File: rtl/tess_factor_unit_if.sv
// ---------------------------------------------------------------------------
// tess_factor_unit_if
// Patch-in / factors-out bundle of the tessellation-factor unit.
//   in_valid/in_ready   : patch handshake
//   in_mode             : 0 = triangle, 1 = quad
//   cfg_alpha/cfg_target: per-patch length scale and target segment length
//   x0..y3              : signed Q12.4 control points
//   out_valid/out_ready : result handshake
//   outer0..3, inner0..1: tess factors
// Modports: master = patch producer / factor consumer, slave = the unit.
// ---------------------------------------------------------------------------
interface tess_factor_unit_if #(
  parameter int COORD_W = 16,
  parameter int TF_W    = 8,
  parameter int ALPHA_W = 4
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic [ALPHA_W-1:0]        cfg_alpha;
  logic [COORD_W-1:0]        cfg_target;
  logic signed [COORD_W-1:0] x0, y0, x1, y1, x2, y2, x3, y3;
  logic                      out_valid;
  logic                      out_ready;
  logic [TF_W-1:0]           outer0, outer1, outer2, outer3;
  logic [TF_W-1:0]           inner0, inner1;

  modport master (
    output in_valid, in_mode, cfg_alpha, cfg_target,
    output x0, y0, x1, y1, x2, y2, x3, y3,
    output out_ready,
    input  in_ready, out_valid,
    input  outer0, outer1, outer2, outer3, inner0, inner1
  );

  modport slave (
    input  in_valid, in_mode, cfg_alpha, cfg_target,
    input  x0, y0, x1, y1, x2, y2, x3, y3,
    input  out_ready,
    output in_ready, out_valid,
    output outer0, outer1, outer2, outer3, inner0, inner1
  );

endinterface

// File: rtl/tess_seq_div.sv
// ---------------------------------------------------------------------------
// tess_seq_div
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands; the first bit is resolved on this edge
//   dividend   : DIVIDEND_W-bit numerator
//   divisor    : DIVISOR_W-bit denominator (0 yields a meaningless result)
//   busy       : iteration in progress
//   done       : 1-cycle pulse exactly DIVIDEND_W cycles after start
//   quotient   : result, stable from done until the next start
// ---------------------------------------------------------------------------
module tess_seq_div #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem, rem_next, src_rem, src_div, div_q;
  logic [DIVIDEND_W-1:0] quo, quo_next, src_quo;
  logic [DIVISOR_W:0]    shifted, diff;
  logic                  ge;
  logic [CNT_W-1:0]      cnt;
  logic                  busy_q, done_q;

  // One restoring step. On start the step works on the fresh operands so
  // that the full quotient is ready after DIVIDEND_W edges including start.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_quo  = start ? dividend : quo;
    src_div  = start ? divisor : div_q;
    shifted  = {src_rem, src_quo[DIVIDEND_W-1]};
    diff     = shifted - {1'b0, src_div};
    ge       = (shifted >= {1'b0, src_div});
    rem_next = ge ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
    quo_next = {src_quo[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= '0;
      quo    <= '0;
      div_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem    <= rem_next;
        quo    <= quo_next;
        div_q  <= divisor;
        cnt    <= CNT_W'(DIVIDEND_W - 1);
        busy_q <= (DIVIDEND_W > 1);
        done_q <= (DIVIDEND_W == 1);
      end else if (busy_q) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo;

endmodule

// File: rtl/tess_factor_unit.sv
// ---------------------------------------------------------------------------
// tess_factor_unit
// Adaptive tessellation-factor generator. Latches one patch, then for each
// edge forms an approximate screen length, scales it by alpha, divides by
// the target segment length on a shared serial divider and clamps the
// result to [TMIN, TMAX]. Quad: 4 outer + 2 diagonal divisions. Tri: 3
// outer divisions, inner0 = max outer.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : tess_factor_unit_if slave (patch in, factors out)
// ---------------------------------------------------------------------------
module tess_factor_unit
  import tess_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int TF_W    = 8,
  parameter int ALPHA_W = 4,
  parameter int TMIN    = 1,
  parameter int TMAX    = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  tess_factor_unit_if.slave   bus
);

  localparam int LEN_W = len_w(COORD_W);
  localparam int SC_W  = sc_w(COORD_W, ALPHA_W);
  localparam int DW    = COORD_W + 1;

  localparam logic [SC_W-1:0] TMIN_Q = SC_W'(TMIN);
  localparam logic [SC_W-1:0] TMAX_Q = SC_W'(TMAX);
  localparam logic [TF_W-1:0] TMIN_F = TF_W'(TMIN);
  localparam logic [TF_W-1:0] TMAX_F = TF_W'(TMAX);

  tess_state_e               state, state_next;
  tess_mode_e                mode_q;
  logic [ALPHA_W-1:0]        alpha_q;
  logic [COORD_W-1:0]        target_q;
  logic signed [COORD_W-1:0] vx [4];
  logic signed [COORD_W-1:0] vy [4];
  logic [2:0]                idx;
  logic [TF_W-1:0]           res [6];
  logic [TF_W-1:0]           res_next [6];
  logic [TF_W-1:0]           outer_q [4];
  logic [TF_W-1:0]           inner_q [2];

  vpair_t                    pair;
  logic signed [DW-1:0]      dx, dy;
  logic [DW-1:0]             adx, ady, mx, mn;
  logic [LEN_W-1:0]          len;
  logic [SC_W-1:0]           scaled;
  logic                      div_start, div_busy, div_done;
  logic [SC_W-1:0]           quotient;
  logic [TF_W-1:0]           factor, tri_max;
  logic                      is_last, accept, finish_edge;

  assign accept      = (state == IDLE) && bus.in_valid;
  assign is_last     = (idx == last_idx(mode_q));
  assign finish_edge = (state == DIV) && div_done;

  // Length of the current edge: max(|dx|,|dy|) + min(|dx|,|dy|)/2, then
  // alpha*len with target/2 added so the later floor division rounds.
  always_comb begin
    pair   = edge_pair(mode_q, idx);
    dx     = {vx[pair.a][COORD_W-1], vx[pair.a]} - {vx[pair.b][COORD_W-1], vx[pair.b]};
    dy     = {vy[pair.a][COORD_W-1], vy[pair.a]} - {vy[pair.b][COORD_W-1], vy[pair.b]};
    adx    = dx[DW-1] ? DW'(-dx) : DW'(dx);
    ady    = dy[DW-1] ? DW'(-dy) : DW'(dy);
    mx     = (adx >= ady) ? adx : ady;
    mn     = (adx >= ady) ? ady : adx;
    len    = LEN_W'(mx) + LEN_W'(mn >> 1);
    scaled = SC_W'(alpha_q) * SC_W'(len) + SC_W'(target_q >> 1);
  end

  // Clamp the quotient; a zero target means "as fine as allowed".
  always_comb begin
    if (target_q == '0)         factor = TMAX_F;
    else if (quotient < TMIN_Q) factor = TMIN_F;
    else if (quotient > TMAX_Q) factor = TMAX_F;
    else                        factor = quotient[TF_W-1:0];
  end

  // Result set including the factor finishing this cycle, so the final
  // edge and the tri inner max can be committed in the same edge.
  always_comb begin
    for (int i = 0; i < 6; i++) res_next[i] = res[i];
    res_next[idx] = factor;
    tri_max = res_next[0];
    if (res_next[1] > tri_max) tri_max = res_next[1];
    if (res_next[2] > tri_max) tri_max = res_next[2];
  end

  // FSM next state and divider launch.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) state_next = LEN;
      LEN: begin
        div_start = !div_busy;
        if (!div_busy) state_next = DIV;
      end
      DIV: if (div_done) state_next = is_last ? OUT : LEN;
      OUT: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Patch capture, per-edge result registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= TESS_TRI;
      alpha_q  <= '0;
      target_q <= '0;
      idx      <= '0;
      for (int i = 0; i < 4; i++) begin
        vx[i]      <= '0;
        vy[i]      <= '0;
        outer_q[i] <= '0;
      end
      for (int i = 0; i < 6; i++) res[i] <= '0;
      inner_q[0] <= '0;
      inner_q[1] <= '0;
    end else begin
      if (accept) begin
        mode_q   <= tess_mode_e'(bus.in_mode);
        alpha_q  <= bus.cfg_alpha;
        target_q <= bus.cfg_target;
        idx      <= '0;
        vx[0] <= bus.x0; vy[0] <= bus.y0;
        vx[1] <= bus.x1; vy[1] <= bus.y1;
        vx[2] <= bus.x2; vy[2] <= bus.y2;
        vx[3] <= bus.x3; vy[3] <= bus.y3;
      end
      if (finish_edge) begin
        for (int i = 0; i < 6; i++) res[i] <= res_next[i];
        if (!is_last) begin
          idx <= idx + 3'd1;
        end else if (mode_q == TESS_QUAD) begin
          for (int i = 0; i < 4; i++) outer_q[i] <= res_next[i];
          inner_q[0] <= res_next[4];
          inner_q[1] <= res_next[5];
        end else begin
          for (int i = 0; i < 3; i++) outer_q[i] <= res_next[i];
          outer_q[3] <= '0;
          inner_q[0] <= tri_max;
          inner_q[1] <= '0;
        end
      end
    end
  end

  tess_seq_div #(
    .DIVIDEND_W (SC_W),
    .DIVISOR_W  (COORD_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (scaled),
    .divisor  (target_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.outer0    = outer_q[0];
  assign bus.outer1    = outer_q[1];
  assign bus.outer2    = outer_q[2];
  assign bus.outer3    = outer_q[3];
  assign bus.inner0    = inner_q[0];
  assign bus.inner1    = inner_q[1];

endmodule

// File: tb/tb_tess_factor_unit.sv
// ---------------------------------------------------------------------------
// tb_tess_factor_unit
// Directed testbench for tess_factor_unit: quad/tri patches with
// hand-computed factors, clamps, zero target, negative coordinates,
// output backpressure and reset in the middle of a division.
// ---------------------------------------------------------------------------
module tb_tess_factor_unit;

  localparam int COORD_W = 16;
  localparam int TF_W    = 8;
  localparam int ALPHA_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   test_count = 0;
  int   fail_count = 0;

  tess_factor_unit_if #(.COORD_W(COORD_W), .TF_W(TF_W), .ALPHA_W(ALPHA_W)) bus ();

  tess_factor_unit #(
    .COORD_W (COORD_W),
    .TF_W    (TF_W),
    .ALPHA_W (ALPHA_W),
    .TMIN    (1),
    .TMAX    (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported with tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a patch at a negedge and complete the handshake on the next posedge.
  task automatic applyStimulus(input string tag, input logic mode, input int alpha, input int target,
                               input int ax0, input int ay0, input int ax1, input int ay1,
                               input int ax2, input int ay2, input int ax3, input int ay3);
    @(negedge clk);
    checkOutput({tag, "_in_ready_before"}, bus.in_ready, 1);
    bus.in_mode    = mode;
    bus.cfg_alpha  = ALPHA_W'(alpha);
    bus.cfg_target = COORD_W'(target);
    bus.x0 = COORD_W'(ax0); bus.y0 = COORD_W'(ay0);
    bus.x1 = COORD_W'(ax1); bus.y1 = COORD_W'(ay1);
    bus.x2 = COORD_W'(ax2); bus.y2 = COORD_W'(ay2);
    bus.x3 = COORD_W'(ax3); bus.y3 = COORD_W'(ay3);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput({tag, "_in_ready_after"}, bus.in_ready, 0);
  endtask

  // Counts cycles from the handshake (cycle 0) to the first out_valid.
  task automatic waitForOutput(input string tag, input int exp_lat);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 400);
    checkOutput({tag, "_latency"}, cyc, exp_lat);
  endtask

  task automatic expectFactors(input string tag, input int o0, input int o1, input int o2,
                               input int o3, input int i0, input int i1);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 1);
    checkOutput({tag, "_outer0"}, bus.outer0, o0);
    checkOutput({tag, "_outer1"}, bus.outer1, o1);
    checkOutput({tag, "_outer2"}, bus.outer2, o2);
    checkOutput({tag, "_outer3"}, bus.outer3, o3);
    checkOutput({tag, "_inner0"}, bus.inner0, i0);
    checkOutput({tag, "_inner1"}, bus.inner1, i1);
  endtask

  // Take the result; the unit must be idle and ready in the following cycle.
  task automatic consumeOutput(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_out_valid_after_take"}, bus.out_valid, 0);
    checkOutput({tag, "_in_ready_after_take"}, bus.in_ready, 1);
  endtask

  // Safety net against a hung design.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.cfg_alpha = '0; bus.cfg_target = '0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_outer0", bus.outer0, 0);
    checkOutput("reset_inner0", bus.inner0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Quad 8-pixel square.
    applyStimulus("quad_sq", 1'b1, 1, 16, 0, 0, 128, 0, 128, 128, 0, 128);
    waitForOutput("quad_sq", 145);
    expectFactors("quad_sq", 8, 8, 8, 8, 12, 12);
    consumeOutput("quad_sq");

    // Triangle.
    applyStimulus("tri", 1'b0, 1, 16, 0, 0, 320, 0, 0, 160, 999, -999);
    waitForOutput("tri", 73);
    expectFactors("tri", 20, 25, 10, 0, 25, 0);
    consumeOutput("tri");

    // Upper clamp.
    applyStimulus("quad_big", 1'b1, 1, 16, 0, 0, 4096, 0, 4096, 4096, 0, 4096);
    waitForOutput("quad_big", 145);
    expectFactors("quad_big", 64, 64, 64, 64, 64, 64);
    consumeOutput("quad_big");

    // Lower clamp: degenerate patch.
    applyStimulus("quad_pt", 1'b1, 1, 16, 100, -50, 100, -50, 100, -50, 100, -50);
    waitForOutput("quad_pt", 145);
    expectFactors("quad_pt", 1, 1, 1, 1, 1, 1);
    consumeOutput("quad_pt");

    // Zero target.
    applyStimulus("quad_t0", 1'b1, 1, 0, 0, 0, 128, 0, 128, 128, 0, 128);
    waitForOutput("quad_t0", 145);
    expectFactors("quad_t0", 64, 64, 64, 64, 64, 64);
    consumeOutput("quad_t0");

    // Negative coordinates, same geometry as the first square.
    applyStimulus("quad_neg", 1'b1, 1, 16, -128, -128, 0, -128, 0, 0, -128, 0);
    waitForOutput("quad_neg", 145);
    expectFactors("quad_neg", 8, 8, 8, 8, 12, 12);
    consumeOutput("quad_neg");

    // Non power-of-two target, alpha 2: (2*128+5)/10=26, (2*192+5)/10=38.
    applyStimulus("quad_a2", 1'b1, 2, 10, 0, 0, 128, 0, 128, 128, 0, 128);
    waitForOutput("quad_a2", 145);
    expectFactors("quad_a2", 26, 26, 26, 26, 38, 38);
    consumeOutput("quad_a2");

    // Backpressure: alpha 3 tri -> 968/16=60, 1208/16=75->64, 488/16=30.
    applyStimulus("bp", 1'b0, 3, 16, 0, 0, 320, 0, 0, 160, 0, 0);
    waitForOutput("bp", 73);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold_out_valid", bus.out_valid, 1);
      checkOutput("bp_hold_in_ready", bus.in_ready, 0);
      checkOutput("bp_hold_outer1", bus.outer1, 64);
      bus.in_valid = i[0];
      bus.x1 = COORD_W'(i * 37);
      bus.cfg_alpha = ALPHA_W'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    expectFactors("bp", 60, 64, 30, 0, 64, 0);
    consumeOutput("bp");

    // Reset in the middle of the third division (cycles 50..72).
    applyStimulus("rst", 1'b0, 1, 16, 0, 0, 320, 0, 0, 160, 0, 0);
    repeat (60) @(negedge clk);
    checkOutput("rst_busy_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_in_ready", bus.in_ready, 1);
    checkOutput("rst_async_out_valid", bus.out_valid, 0);
    checkOutput("rst_async_outer0", bus.outer0, 0);
    checkOutput("rst_async_outer1", bus.outer1, 0);
    checkOutput("rst_async_inner0", bus.inner0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 1'b0, 1, 16, 0, 0, 320, 0, 0, 160, 0, 0);
    waitForOutput("post_rst", 73);
    expectFactors("post_rst", 20, 25, 10, 0, 25, 0);
    consumeOutput("post_rst");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
